// File: rtl/mcp_tx_launcher_pkg.sv
// mcp_tx_launcher_pkg: state encoding, default sync depth and watchdog width helper
package mcp_tx_launcher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_t;

    localparam int DEF_ACK_STAGES = 2;

    // A disabled watchdog still gets a 1-bit counter so the declaration stays legal
    function automatic int cnt_width(int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/mcp_tx_launcher_if.sv
// mcp_tx_launcher_if: producer handshake, destination request/ack and status signals
interface mcp_tx_launcher_if #(
    parameter int BUS_WIDTH = 1
) ();
    logic [BUS_WIDTH-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [BUS_WIDTH-1:0] UNSYNC_bus;
    logic                 bus_enable;
    logic                 ack_async;
    logic                 tx_done;
    logic                 timeout_err;
    logic                 err_clr;

    modport slave (
        input  in_data, in_valid, ack_async, err_clr,
        output in_ready, UNSYNC_bus, bus_enable, tx_done, timeout_err
    );

    modport master (
        output in_data, in_valid, ack_async, err_clr,
        input  in_ready, UNSYNC_bus, bus_enable, tx_done, timeout_err
    );
endinterface

// File: rtl/mcp_tx_launcher_bit_sync.sv
// mcp_tx_launcher_bit_sync: single-bit flop-chain synchronizer with async active-high reset
module mcp_tx_launcher_bit_sync #(
    parameter int NUM_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic [NUM_STAGES-1:0] r_chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_chain <= '0;
        else
            r_chain <= {r_chain[NUM_STAGES-2:0], i_d};
    end

    assign o_q = r_chain[NUM_STAGES-1];
endmodule

// File: rtl/mcp_tx_launcher.sv
// mcp_tx_launcher: source-side MCP launcher; holds a word, runs a 4-phase req/ack
// handshake against a synchronized acknowledge, with an optional watchdog.
module mcp_tx_launcher
    import mcp_tx_launcher_pkg::*;
#(
    parameter int BUS_WIDTH      = 1,
    parameter int ACK_STAGES     = DEF_ACK_STAGES,
    parameter int TIMEOUT_CYCLES = 0
) (
    input logic               CLK,
    input logic               RST,
    mcp_tx_launcher_if.slave  bus
);
    localparam int             CW     = cnt_width(TIMEOUT_CYCLES);
    localparam bit             WD_ON  = TIMEOUT_CYCLES > 0;
    localparam logic [CW-1:0]  C_LAST = CW'(WD_ON ? TIMEOUT_CYCLES - 1 : 0);

    state_t               r_state;
    logic [BUS_WIDTH-1:0] r_data;
    logic [CW-1:0]        r_cnt;
    logic                 r_en;
    logic                 r_done;
    logic                 r_err;
    logic                 w_ack;
    logic                 w_to;
    logic [CW-1:0]        w_cnt_inc;

    mcp_tx_launcher_bit_sync #(.NUM_STAGES(ACK_STAGES)) u_ack_sync (
        .clk (CLK),
        .rst (RST),
        .i_d (bus.ack_async),
        .o_q (w_ack)
    );

    // The edge that would take the count to TIMEOUT_CYCLES is the timeout edge,
    // so the counter never needs to hold more than TIMEOUT_CYCLES-1.
    assign w_cnt_inc = (r_cnt == C_LAST) ? r_cnt : r_cnt + 1'b1;
    assign w_to      = WD_ON && (r_cnt == C_LAST) &&
                       ((r_state == REQ && !w_ack) || (r_state == REL && w_ack));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_cnt   <= '0;
            r_en    <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= w_to ? 1'b1 : bus.err_clr ? 1'b0 : r_err;
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_data  <= bus.in_data;
                    r_en    <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= REQ;
                end
                REQ: if (w_ack || w_to) begin
                    r_en    <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= REL;
                end else begin
                    r_cnt   <= w_cnt_inc;
                end
                // A stuck-high ack only raises the flag; the handshake still waits for it
                REL: if (!w_ack) begin
                    r_done  <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end else begin
                    r_cnt   <= w_to ? '0 : w_cnt_inc;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (r_state == IDLE);
    assign bus.UNSYNC_bus  = r_data;
    assign bus.bus_enable  = r_en;
    assign bus.tx_done     = r_done;
    assign bus.timeout_err = r_err;
endmodule
